// File: rtl/aes_inv_mix_columns_if.sv
// State bus for the AES InvMixColumns stage: input state with valid, transformed state with valid.
interface aes_inv_mix_columns_if;
  logic         in_valid;
  logic [127:0] state_in;
  logic [127:0] state_out;
  logic         out_valid;

  modport master (output in_valid, output state_in, input state_out, input out_valid);
  modport slave  (input in_valid, input state_in, output state_out, output out_valid);
endinterface

// File: rtl/aes_inv_mix_columns.sv
// AES InvMixColumns on a 128-bit column-major state, xtime-chain GF(2^8) arithmetic.
// Optional single-cycle output register with valid flag, or a purely combinational path.
module aes_inv_mix_columns #(
  parameter bit REGISTER_OUTPUT = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  aes_inv_mix_columns_if.slave bus
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] s  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]  = col[31 - 8*i -: 8];
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ s[i];
      mb[i] = x8[i] ^ x2[i] ^ s[i];
      md[i] = x8[i] ^ x4[i] ^ s[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [127:0] mixed;

  always_comb begin
    mixed = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      mixed[127 - 32*c -: 32] = inv_mix_col(bus.state_in[127 - 32*c -: 32]);
    end
  end

  generate
    if (REGISTER_OUTPUT) begin : g_reg
      logic [127:0] state_q;
      logic         valid_q;

      // State only loads on valid so idle cycles hold the last result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= bus.in_valid;
          if (bus.in_valid) state_q <= mixed;
        end
      end

      assign bus.state_out = state_q;
      assign bus.out_valid = valid_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign bus.state_out  = mixed;
      assign bus.out_valid  = bus.in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_aes_inv_mix_columns.sv
// Directed and round-trip checks of InvMixColumns in registered and combinational builds.
module tb_aes_inv_mix_columns;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  aes_inv_mix_columns_if if_r ();
  aes_inv_mix_columns_if if_c ();

  aes_inv_mix_columns #(.REGISTER_OUTPUT(1'b1)) dut_reg (.clk(clk), .rst_n(rst_n), .bus(if_r));
  aes_inv_mix_columns #(.REGISTER_OUTPUT(1'b0)) dut_comb (.clk(clk), .rst_n(rst_n), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] GOLD_IN  = {4{32'h046681E5}};
  localparam logic [127:0] GOLD_OUT = {4{32'hD4BF5D30}};
  localparam logic [127:0] MIX_IN   = 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6;
  localparam logic [127:0] MIX_OUT  = 128'hDB135345_F20A225C_01010101_C6C6C6C6;
  localparam logic [127:0] MORE_IN  = 128'hD5D5D7D6_4D7EBDF8_00000000_FFFFFFFF;
  localparam logic [127:0] MORE_OUT = 128'hD4D4D4D5_2D26314C_00000000_FFFFFFFF;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forward MixColumns reference used to build round-trip stimulus.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] st);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = st[127 - 32*c -: 8];
      a1 = st[119 - 32*c -: 8];
      a2 = st[111 - 32*c -: 8];
      a3 = st[103 - 32*c -: 8];
      r[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction

  initial begin
    logic [127:0] s, m;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    if_r.in_valid = 1'b0;
    if_r.state_in = '0;
    if_c.in_valid = 1'b0;
    if_c.state_in = '0;
    #1;
    check("reset_state", if_r.state_out, '0);
    check("reset_valid", 128'(if_r.out_valid), 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    if_r.in_valid = 1'b1;
    if_r.state_in = GOLD_IN;
    tick();
    check("golden_valid", 128'(if_r.out_valid), 128'd1);
    check("golden_state", if_r.state_out, GOLD_OUT);

    if_r.state_in = MIX_IN;
    tick();
    check("mixed_state", if_r.state_out, MIX_OUT);

    if_r.state_in = MORE_IN;
    tick();
    check("stream0_valid", 128'(if_r.out_valid), 128'd1);
    check("stream0_state", if_r.state_out, MORE_OUT);
    if_r.state_in = MIX_IN;
    tick();
    check("stream1_valid", 128'(if_r.out_valid), 128'd1);
    check("stream1_state", if_r.state_out, MIX_OUT);

    if_r.in_valid = 1'b0;
    if_r.state_in = GOLD_IN;
    tick();
    check("gate0_valid", 128'(if_r.out_valid), 128'd0);
    check("gate0_hold", if_r.state_out, MIX_OUT);
    if_r.state_in = MORE_IN;
    tick();
    check("gate1_valid", 128'(if_r.out_valid), 128'd0);
    check("gate1_hold", if_r.state_out, MIX_OUT);

    if_r.in_valid = 1'b1;
    if_r.state_in = GOLD_IN;
    tick();
    check("prerst_valid", 128'(if_r.out_valid), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", if_r.state_out, '0);
    check("async_rst_valid", 128'(if_r.out_valid), 128'd0);
    tick();
    check("in_rst_state", if_r.state_out, '0);
    if_r.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    check("postrst_state", if_r.state_out, '0);
    check("postrst_valid", 128'(if_r.out_valid), 128'd0);
    if_r.in_valid = 1'b1;
    if_r.state_in = MORE_IN;
    tick();
    check("postrst_first_valid", 128'(if_r.out_valid), 128'd1);
    check("postrst_first_state", if_r.state_out, MORE_OUT);

    if_c.in_valid = 1'b1;
    if_c.state_in = GOLD_IN;
    #1;
    check("comb_golden", if_c.state_out, GOLD_OUT);
    check("comb_valid1", 128'(if_c.out_valid), 128'd1);
    if_c.in_valid = 1'b0;
    if_c.state_in = MIX_IN;
    #1;
    check("comb_mixed", if_c.state_out, MIX_OUT);
    check("comb_valid0", 128'(if_c.out_valid), 128'd0);

    if_c.in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      m = mix_cols(s);
      if_r.state_in = m;
      if_c.state_in = m;
      #1;
      check("rt_comb", if_c.state_out, s);
      tick();
      check("rt_reg", if_r.state_out, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
